// File: rtl/psum_pkg.sv
// -----------------------------------------------------------------------------
// psum_pkg
// Shared constants for the partial-sum output path: default column count and
// widths used by both the output buffer and the downstream merger, the signed
// saturation limits for the default partial-sum width, and the accumulator
// state encoding.
// -----------------------------------------------------------------------------
package psum_pkg;

  localparam int PSUM_NUM_COLS    = 32;
  localparam int PSUM_MAC_WIDTH   = 16;
  localparam int PSUM_ODATA_WIDTH = 20;

  // Signed clamp limits of a PSUM_ODATA_WIDTH-bit partial sum
  localparam logic signed [PSUM_ODATA_WIDTH-1:0] PSUM_SAT_MAX =
    {1'b0, {(PSUM_ODATA_WIDTH-1){1'b1}}};
  localparam logic signed [PSUM_ODATA_WIDTH-1:0] PSUM_SAT_MIN =
    {1'b1, {(PSUM_ODATA_WIDTH-1){1'b0}}};

  // FIRST: next accepted beat loads the accumulator; ACCUM: next beat adds
  typedef enum logic {
    ACC_FIRST = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_t;

endpackage

// File: rtl/psum_fifo.sv
// -----------------------------------------------------------------------------
// psum_fifo
// Small circular FIFO holding finished partial-sum vectors. DEPTH need not be
// a power of two; pointers wrap explicitly from DEPTH-1 to 0. The head output
// is forced to zero while the FIFO is empty.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset (pointers and count)
//   i_clear      synchronous flush (pointers and count)
//   i_push       write i_push_data at the write pointer
//   i_push_data  vector to store
//   i_pop        advance the read pointer
//   o_head       entry at the read pointer, zero when empty
//   o_count      number of occupied entries
// -----------------------------------------------------------------------------
module psum_fifo #(
  parameter int WIDTH = 640,
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Storage carries no reset; validity is tracked by r_count alone
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/psum_out_buffer.sv
// -----------------------------------------------------------------------------
// psum_out_buffer
// Accumulates groups of per-column MAC results into saturated partial sums and
// queues each finished group for a merger that acknowledges through a
// registered ack. The offer is dropped combinationally in any ack cycle so the
// merger never captures the same entry twice.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   clear             synchronous flush of accumulator, FIFO and handshake
//   mac_valid/ready   MAC beat handshake; mac_last closes a group
//   mac_data          NUM_COLS signed MAC_WIDTH columns
//   psum_buff_out     FIFO head, NUM_COLS signed ODATA_WIDTH columns
//   psum_data_ready   head offered to the merger
//   psum_ack          merger acknowledge (one cycle after the offer)
//   fifo_count        occupied FIFO entries
//   sat_flag          sticky: some column saturated
//   ack_err           sticky: ack arrived without a preceding offer
// -----------------------------------------------------------------------------
module psum_out_buffer
  import psum_pkg::*;
#(
  parameter int NUM_COLS    = PSUM_NUM_COLS,
  parameter int MAC_WIDTH   = PSUM_MAC_WIDTH,
  parameter int ODATA_WIDTH = PSUM_ODATA_WIDTH,
  parameter int DEPTH       = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            mac_valid,
  input  logic                            mac_last,
  input  logic [NUM_COLS*MAC_WIDTH-1:0]   mac_data,
  output logic                            mac_ready,
  output logic [NUM_COLS*ODATA_WIDTH-1:0] psum_buff_out,
  output logic                            psum_data_ready,
  input  logic                            psum_ack,
  output logic [$clog2(DEPTH+1)-1:0]      fifo_count,
  output logic                            sat_flag,
  output logic                            ack_err
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int VEC_W = NUM_COLS*ODATA_WIDTH;

  localparam logic signed [ODATA_WIDTH-1:0] SAT_MAX = {1'b0, {(ODATA_WIDTH-1){1'b1}}};
  localparam logic signed [ODATA_WIDTH-1:0] SAT_MIN = {1'b1, {(ODATA_WIDTH-1){1'b0}}};

  // Returns {saturated, clamped sum}; overflow shows as the two top bits of
  // the one-bit-wider sum disagreeing.
  function automatic logic [ODATA_WIDTH:0] sat_add(
    input logic signed [ODATA_WIDTH-1:0] a,
    input logic signed [ODATA_WIDTH-1:0] b
  );
    logic signed [ODATA_WIDTH:0] s;
    s = (ODATA_WIDTH+1)'(a) + (ODATA_WIDTH+1)'(b);
    if (s[ODATA_WIDTH] == s[ODATA_WIDTH-1]) begin
      return {1'b0, s[ODATA_WIDTH-1:0]};
    end else if (s[ODATA_WIDTH]) begin
      return {1'b1, SAT_MIN};
    end else begin
      return {1'b1, SAT_MAX};
    end
  endfunction

  acc_state_t          r_state;
  acc_state_t          w_state_nxt;
  logic                w_first;
  logic [VEC_W-1:0]    r_acc;
  logic [VEC_W-1:0]    w_sum;
  logic [NUM_COLS-1:0] w_sat_col;
  logic                r_offered;
  logic                r_sat;
  logic                r_ack_err;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic [CNT_W-1:0]    w_count;
  logic [VEC_W-1:0]    w_head;

  // Handshake: ready is based on the registered count only, so a pop in the
  // same cycle never opens the input.
  assign mac_ready       = (w_count < CNT_W'(DEPTH)) && !clear;
  assign w_accept        = mac_valid && mac_ready;
  assign w_push          = w_accept && mac_last;
  assign psum_data_ready = (w_count != '0) && !psum_ack && !clear;
  assign w_pop           = psum_ack && r_offered && (w_count != '0) && !clear;

  // Accumulator FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ACC_FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ACC_FIRST;
    end else if (w_accept) begin
      w_state_nxt = mac_last ? ACC_FIRST : ACC_ACCUM;
    end
  end

  // Accumulator FSM: outputs
  always_comb begin
    w_first = (r_state == ACC_FIRST);
  end

  // Per-column load or saturating add
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic signed [MAC_WIDTH-1:0]   w_mac;
    logic signed [ODATA_WIDTH-1:0] w_ext;
    logic signed [ODATA_WIDTH-1:0] w_acc;
    logic        [ODATA_WIDTH:0]   w_res;

    assign w_mac = mac_data[c*MAC_WIDTH +: MAC_WIDTH];
    assign w_ext = ODATA_WIDTH'(w_mac);
    assign w_acc = r_acc[c*ODATA_WIDTH +: ODATA_WIDTH];
    assign w_res = sat_add(w_acc, w_ext);

    assign w_sum[c*ODATA_WIDTH +: ODATA_WIDTH] = w_first ? w_ext : w_res[ODATA_WIDTH-1:0];
    assign w_sat_col[c] = !w_first && w_res[ODATA_WIDTH];
  end

  // Running sum; the pushed value comes straight from w_sum, so r_acc only
  // matters while the group is open.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum;
    end
  end

  // Offer tracking and sticky status; clear leaves the sticky flags alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_offered <= 1'b0;
      r_sat     <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_offered <= psum_data_ready;
      if (w_accept && (|w_sat_col)) r_sat     <= 1'b1;
      if (psum_ack && !r_offered)   r_ack_err <= 1'b1;
    end
  end

  psum_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (clear),
    .i_push      (w_push),
    .i_push_data (w_sum),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign psum_buff_out = w_head;
  assign fifo_count    = w_count;
  assign sat_flag      = r_sat;
  assign ack_err       = r_ack_err;

endmodule

// File: tb/tb_psum_out_buffer.sv
module tb_psum_out_buffer;

  localparam int NC   = 4;
  localparam int MW   = 16;
  localparam int OW   = 20;
  localparam int DP   = 2;
  localparam int CW   = $clog2(DP+1);
  localparam int VW   = NC*OW;
  localparam int DW   = NC*MW;
  localparam int SMAX = (1 << (OW-1)) - 1;
  localparam int SMIN = -(1 << (OW-1));

  logic          clk = 1'b0;
  logic          rst_n, clear, mac_valid, mac_last, psum_ack;
  logic [DW-1:0] mac_data;
  logic          mac_ready, psum_data_ready, sat_flag, ack_err;
  logic [VW-1:0] psum_buff_out;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  psum_out_buffer #(
    .NUM_COLS    (NC),
    .MAC_WIDTH   (MW),
    .ODATA_WIDTH (OW),
    .DEPTH       (DP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .mac_valid       (mac_valid),
    .mac_last        (mac_last),
    .mac_data        (mac_data),
    .mac_ready       (mac_ready),
    .psum_buff_out   (psum_buff_out),
    .psum_data_ready (psum_data_ready),
    .psum_ack        (psum_ack),
    .fifo_count      (fifo_count),
    .sat_flag        (sat_flag),
    .ack_err         (ack_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [VW-1:0] mkvec(input int c0, input int c1 = 0,
                                          input int c2 = 0, input int c3 = 0);
    int cs[NC];
    logic [VW-1:0] v;
    cs = '{c0, c1, c2, c3};
    v = '0;
    for (int c = 0; c < NC; c++) v[c*OW +: OW] = cs[c][OW-1:0];
    return v;
  endfunction

  function automatic logic [DW-1:0] mkdat(input int c0, input int c1 = 0,
                                          input int c2 = 0, input int c3 = 0);
    int cs[NC];
    logic [DW-1:0] v;
    cs = '{c0, c1, c2, c3};
    v = '0;
    for (int c = 0; c < NC; c++) v[c*MW +: MW] = cs[c][MW-1:0];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit r, input bit clr, input bit v, input bit l,
                        input logic [DW-1:0] d, input bit a);
    rst_n = r; clear = clr; mac_valid = v; mac_last = l; mac_data = d; psum_ack = a;
  endtask

  task automatic chk_out(input string tag, input bit rdy, input bit drdy, input int cnt,
                         input logic [VW-1:0] buff, input bit sat, input bit aerr);
    #1;
    chk({tag, ".mac_ready"},  128'(mac_ready),       128'(rdy));
    chk({tag, ".data_ready"}, 128'(psum_data_ready), 128'(drdy));
    chk({tag, ".fifo_count"}, 128'(fifo_count),      128'(cnt));
    chk({tag, ".buff_out"},   128'(psum_buff_out),   128'(buff));
    chk({tag, ".sat_flag"},   128'(sat_flag),        128'(sat));
    chk({tag, ".ack_err"},    128'(ack_err),         128'(aerr));
  endtask

  // Directed cycle table: inputs applied in a cycle, outputs expected in that
  // same cycle (before the edge that consumes the inputs).
  typedef struct {
    bit rst_n; bit clr; bit vld; bit last; int d0; bit ack;
    bit e_rdy; bit e_drdy; int e_cnt; int e_col0; bit e_sat; bit e_aerr;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl[NV];

  // Behavioural reference: queue of finished vectors plus integer running sums
  int            m_acc[NC];
  bit            m_in, m_off, m_sat, m_aerr;
  logic [VW-1:0] m_q[$];
  logic [VW-1:0] exp_list[$];

  task automatic model_reset();
    m_q.delete();
    for (int c = 0; c < NC; c++) m_acc[c] = 0;
    m_in = 0; m_off = 0; m_sat = 0; m_aerr = 0;
  endtask

  task automatic model_edge(input bit clr, input bit vld, input bit last,
                            input int d[NC], input bit ack);
    bit accept, dr, pop;
    logic [VW-1:0] e;
    int v;
    accept = vld && (m_q.size() < DP) && !clr;
    dr     = (m_q.size() != 0) && !ack && !clr;
    pop    = ack && m_off && (m_q.size() != 0) && !clr;
    if (ack && !m_off) m_aerr = 1;
    if (clr) begin
      m_q.delete();
      m_in = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (accept) begin
        e = '0;
        for (int c = 0; c < NC; c++) begin
          v = m_in ? m_acc[c] + d[c] : d[c];
          if (v > SMAX) begin v = SMAX; m_sat = 1; end
          if (v < SMIN) begin v = SMIN; m_sat = 1; end
          m_acc[c] = v;
          e[c*OW +: OW] = v[OW-1:0];
        end
        if (last) begin
          m_q.push_back(e);
          exp_list.push_back(e);
        end
        m_in = !last;
      end
    end
    m_off = dr;
  endtask

  initial begin
    int d[NC];
    logic [DW-1:0] dv;
    bit vld, last, m_ack, nxt_ack, e_rdy, e_drdy;
    logic [VW-1:0] e_buff;
    int cap_idx;

    tbl[0]  = '{1,0,1,0, 100,0, 1,0,0,  0,0,0};
    tbl[1]  = '{1,0,1,0, 200,0, 1,0,0,  0,0,0};
    tbl[2]  = '{1,0,1,1, -50,0, 1,0,0,  0,0,0};
    tbl[3]  = '{1,0,0,0,   0,0, 1,1,1,250,0,0};
    tbl[4]  = '{1,0,0,0,   0,1, 1,0,1,250,0,0};
    tbl[5]  = '{1,0,0,0,   0,0, 1,0,0,  0,0,0};
    tbl[6]  = '{1,0,1,1,   1,0, 1,0,0,  0,0,0};
    tbl[7]  = '{1,0,1,1,   2,0, 1,1,1,  1,0,0};
    tbl[8]  = '{1,0,1,1,   3,0, 0,1,2,  1,0,0};
    tbl[9]  = '{1,0,1,1,   3,1, 0,0,2,  1,0,0};
    tbl[10] = '{1,0,1,1,   3,0, 1,1,1,  2,0,0};
    tbl[11] = '{1,0,0,0,   0,0, 0,1,2,  2,0,0};
    tbl[12] = '{1,0,0,0,   0,1, 0,0,2,  2,0,0};
    tbl[13] = '{1,0,0,0,   0,0, 1,1,1,  3,0,0};
    tbl[14] = '{1,0,0,0,   0,1, 1,0,1,  3,0,0};
    tbl[15] = '{1,0,0,0,   0,0, 1,0,0,  0,0,0};
    tbl[16] = '{1,0,0,0,   0,1, 1,0,0,  0,0,0};
    tbl[17] = '{1,0,0,0,   0,0, 1,0,0,  0,0,1};
    tbl[18] = '{1,0,1,1,   7,0, 1,0,0,  0,0,1};
    tbl[19] = '{1,0,0,0,   0,0, 1,1,1,  7,0,1};
    tbl[20] = '{1,0,1,1,   8,1, 1,0,1,  7,0,1};
    tbl[21] = '{1,0,0,0,   0,0, 1,1,1,  8,0,1};
    tbl[22] = '{1,0,0,0,   0,1, 1,0,1,  8,0,1};
    tbl[23] = '{1,0,0,0,   0,0, 1,0,0,  0,0,1};

    set_in(0, 0, 0, 0, '0, 0);
    tick();
    tick();

    for (int i = 0; i < NV; i++) begin
      set_in(tbl[i].rst_n, tbl[i].clr, tbl[i].vld, tbl[i].last, mkdat(tbl[i].d0), tbl[i].ack);
      chk_out($sformatf("tbl%0d", i), tbl[i].e_rdy, tbl[i].e_drdy, tbl[i].e_cnt,
              mkvec(tbl[i].e_col0), tbl[i].e_sat, tbl[i].e_aerr);
      tick();
    end

    // Saturation: 17 beats, col0 up, col1 down, col2 unsaturated
    for (int i = 0; i < 17; i++) begin
      set_in(1, 0, 1, (i == 16), mkdat(32767, -32768, 1, 0), 0);
      #1;
      if (i == 16) chk("sat.not_yet", 128'(sat_flag), 128'(0));
      tick();
    end
    set_in(1, 0, 0, 0, '0, 0);
    chk_out("sat.res", 1, 1, 1, mkvec(SMAX, SMIN, 17, 0), 1, 1);
    tick();
    set_in(1, 0, 0, 0, '0, 1);
    chk_out("sat.ack", 1, 0, 1, mkvec(SMAX, SMIN, 17, 0), 1, 1);
    tick();
    set_in(1, 0, 0, 0, '0, 0);
    chk_out("sat.hold", 1, 0, 0, '0, 1, 1);
    tick();

    // Clear with an entry queued and a group in ACCUM, then with a full FIFO
    set_in(1, 0, 1, 1, mkdat(10), 0);    chk_out("clr.a", 1, 0, 0, '0, 1, 1);        tick();
    set_in(1, 0, 1, 0, mkdat(1000), 0);  chk_out("clr.b", 1, 1, 1, mkvec(10), 1, 1); tick();
    set_in(1, 1, 1, 1, mkdat(2000), 0);  chk_out("clr.c", 0, 0, 1, mkvec(10), 1, 1); tick();
    set_in(1, 0, 1, 0, mkdat(5), 0);     chk_out("clr.d", 1, 0, 0, '0, 1, 1);        tick();
    set_in(1, 0, 1, 1, mkdat(6), 0);     chk_out("clr.e", 1, 0, 0, '0, 1, 1);        tick();
    set_in(1, 0, 0, 0, '0, 0);           chk_out("clr.f", 1, 1, 1, mkvec(11), 1, 1); tick();
    set_in(1, 0, 1, 1, mkdat(12), 0);    chk_out("clr.g", 1, 1, 1, mkvec(11), 1, 1); tick();
    set_in(1, 1, 0, 0, '0, 0);           chk_out("clr.h", 0, 0, 2, mkvec(11), 1, 1); tick();
    set_in(1, 0, 0, 0, '0, 0);           chk_out("clr.i", 1, 0, 0, '0, 1, 1);        tick();

    // Reset with an entry pending and a group open
    set_in(1, 0, 1, 1, mkdat(20), 0);    chk_out("rst.a", 1, 0, 0, '0, 1, 1);        tick();
    set_in(1, 0, 1, 0, mkdat(300), 0);   chk_out("rst.b", 1, 1, 1, mkvec(20), 1, 1); tick();
    set_in(0, 0, 1, 1, mkdat(99), 0);    chk_out("rst.c", 1, 1, 1, mkvec(20), 1, 1); tick();
    set_in(1, 0, 0, 0, '0, 0);           chk_out("rst.d", 1, 0, 0, '0, 0, 0);        tick();
    set_in(1, 0, 1, 1, mkdat(4), 0);     chk_out("rst.e", 1, 0, 0, '0, 0, 0);        tick();
    set_in(1, 0, 0, 0, '0, 0);           chk_out("rst.f", 1, 1, 1, mkvec(4), 0, 0);  tick();
    set_in(1, 0, 0, 0, '0, 1);           chk_out("rst.g", 1, 0, 1, mkvec(4), 0, 0);  tick();
    set_in(1, 0, 0, 0, '0, 0);           chk_out("rst.h", 1, 0, 0, '0, 0, 0);        tick();

    // Randomized traffic against the reference, with a registered-ack merger
    set_in(0, 0, 0, 0, '0, 0);
    tick();
    model_reset();
    exp_list.delete();
    m_ack = 0;
    cap_idx = 0;
    for (int cyc = 0; cyc < 2030; cyc++) begin
      vld  = (cyc < 2000) && ($urandom_range(0, 3) != 0);
      last = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < NC; c++) begin
        case ($urandom_range(0, 7))
          0:       d[c] = 32767;
          1:       d[c] = -32768;
          default: d[c] = int'($urandom_range(0, 2000)) - 1000;
        endcase
        dv[c*MW +: MW] = d[c][MW-1:0];
      end
      set_in(1, 0, vld, last, dv, m_ack);
      e_rdy  = (m_q.size() < DP);
      e_drdy = (m_q.size() != 0) && !m_ack;
      e_buff = (m_q.size() != 0) ? m_q[0] : '0;
      chk_out($sformatf("rnd%0d", cyc), e_rdy, e_drdy, m_q.size(), e_buff, m_sat, m_aerr);
      if (psum_data_ready) begin
        if (cap_idx < exp_list.size())
          chk($sformatf("cap%0d", cap_idx), 128'(psum_buff_out), 128'(exp_list[cap_idx]));
        else
          chk("cap_extra", 128'(cap_idx), 128'(exp_list.size()));
        cap_idx++;
      end
      nxt_ack = psum_data_ready;
      model_edge(0, vld, last, d, m_ack);
      m_ack = nxt_ack;
      tick();
    end
    chk("cap_count", 128'(cap_idx), 128'(exp_list.size()));
    chk("drain_empty", 128'(fifo_count), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/psum_out_buffer.md
PSUM_OUT_BUFFER -- requirements
Module: psum_out_buffer

Interface
REQ-001 Parameter NUM_COLS, default 32: number of output columns per sub-macro.
REQ-002 Parameter MAC_WIDTH, default 16: signed per-column MAC result width.
REQ-003 Parameter ODATA_WIDTH, default 20: signed per-column partial-sum width presented to the merger.
REQ-004 Parameter DEPTH, default 2, minimum 1, need not be a power of 2: number of partial-sum vectors the FIFO holds.
REQ-005 One clock; reset is synchronous and active-low: clk  in  1  clock, all state updates on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 clear  in  1  synchronous flush of accumulator, FIFO and handshake state.
REQ-008 mac_valid  in  1  mac_data beat present.
REQ-009 mac_last  in  1  beat closes the current accumulation group.
REQ-010 mac_data  in  NUM_COLS*MAC_WIDTH  signed column c at [c*MAC_WIDTH +: MAC_WIDTH].
REQ-011 mac_ready  out  1  beat accepted at the edge where mac_valid=1 and mac_ready=1.
REQ-012 psum_buff_out  out  NUM_COLS*ODATA_WIDTH  FIFO head entry, column c at [c*ODATA_WIDTH +: ODATA_WIDTH].
REQ-013 psum_data_ready  out  1  head entry offered to the merger.
REQ-014 psum_ack  in  1  merger acknowledge, registered on the merger side (arrives one cycle after ready is sampled).
REQ-015 fifo_count  out  $clog2(DEPTH+1)  occupied entries.
REQ-016 sat_flag  out  1  sticky; any column saturated.
REQ-017 ack_err  out  1  sticky; psum_ack=1 in a cycle where offered_q=0.

Function
REQ-018 Accumulator has states FIRST and ACCUM; the first accepted beat of a group loads each column sign-extended to ODATA_WIDTH; subsequent beats add sign-extended mac_data.
REQ-019 Every add saturates to [-2^(ODATA_WIDTH-1), 2^(ODATA_WIDTH-1)-1] per column independently; any saturation sets sat_flag.
REQ-020 An accepted beat with mac_last=1 pushes the final (saturated) sum into the FIFO at the same edge and returns the accumulator to FIFO state FIRST; beats with mac_last=0 move it to ACCUM.
REQ-021 mac_ready = (fifo_count < DEPTH) AND NOT clear, from registered count only; a pop in the same cycle does not raise mac_ready.
REQ-022 psum_data_ready = (fifo_count != 0) AND NOT psum_ack AND NOT clear (combinational on psum_ack, preventing duplicate capture by the registered-ack merger).
REQ-023 Register offered_q <= psum_data_ready every cycle.
REQ-024 Pop occurs at the edge where psum_ack=1, offered_q=1 and fifo_count!=0; read pointer advances.
REQ-025 psum_ack=1 with offered_q=0 causes no pop and sets ack_err.
REQ-026 psum_buff_out stays stable while psum_data_ready or offered_q is high; it reads all zeros when fifo_count=0.
REQ-027 Simultaneous push and pop: both pointers advance, fifo_count unchanged.
REQ-028 Pointers wrap from DEPTH-1 to 0.
REQ-029 Latency: mac_last beat accepted at edge k gives psum_data_ready=1 in cycle k+1 (FIFO previously empty, psum_ack=0).
REQ-030 Output throughput is one entry per 2 cycles maximum (offer, ack).
REQ-031 clear=1 at an edge: empties FIFO, resets pointers, returns accumulator to FIRST and sets offered_q=0; any mac beat in that cycle is dropped; sat_flag and ack_err are kept.

Reset
REQ-032 rst_n=0 at an edge: fifo_count=0, pointers=0, accumulator FIRST and zero, offered_q=0, sat_flag=0, ack_err=0; hence psum_data_ready=0, psum_buff_out=0, mac_ready=1 in the next cycle.
REQ-033 Reset mid-group or with entries pending discards all data; no push or pop occurs at the reset edge.

Structure
REQ-034 Package psum_pkg holds default NUM_COLS, MAC_WIDTH and ODATA_WIDTH constants shared with the merger, plus the signed saturation limit constants.
REQ-035 A sub-module psum_fifo (storage, pointers, count, push/pop) is instantiated once; accumulation and handshake logic stay in psum_out_buffer.

Verification
REQ-036 Single group: beats col0=100, 200, -50 (last) -> one push, psum_buff_out col0=250, psum_data_ready high cycle after last; ack -> fifo_count 0.
REQ-037 Saturation: MAC_WIDTH 16, 17 beats of 32767 -> col0=524287 (2^19-1), sat_flag=1 and stays set until reset.
REQ-038 Fill: DEPTH=2, 3 single-beat groups, no ack -> mac_ready=0 after 2nd push, fifo_count=2, 3rd beat held; one ack -> accepted next cycle.
REQ-039 Handshake: merger model (registered ack) -> each entry captured exactly once; ready low in every ack cycle; entries in FIFO order.
REQ-040 Spurious ack with FIFO empty -> ack_err=1, fifo_count unchanged at 0.
REQ-041 clear with 2 entries and a group in ACCUM -> fifo_count=0, psum_data_ready=0; next group result excludes pre-clear beats.
